// File: rtl/dm_stage.sv
// Memory-stage data memory: byte/halfword/word stores, synchronous read-first load,
// W-side pipeline register. Define DM_WRITE_LOG_EN to log every effective write.
module dm_stage #(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  st_type,
    input  logic [1:0]  ld_sel,
    output logic [31:0] rdata,
    output logic [1:0]  addr_lo,
    output logic [1:0]  sel_o,
    output logic        valid,
    output logic        align_err
);

    typedef enum logic [1:0] {
        ST_SW  = 2'd0,
        ST_SH  = 2'd1,
        ST_SB  = 2'd2,
        ST_RSV = 2'd3
    } st_e;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          in_range;
    st_e           st;
    logic [3:0]    be;
    logic [3:0]    wr_be;
    logic [31:0]   lane;
    logic          bad;
    logic [31:0]   old_word;
    logic [31:0]   merged_word;
    logic          unused_bits;

    assign idx         = addr[AW+1:2];
    assign in_range    = 32'(idx) < DEPTH;
    assign st          = st_e'(st_type);
    assign unused_bits = ^{pc, addr[31:AW+2]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        be   = 4'b0000;
        lane = wdata;
        bad  = 1'b0;
        case (st)
            ST_SW: begin
                if (addr[1:0] == 2'b00) be = 4'b1111;
                else                    bad = 1'b1;
            end
            ST_SH: begin
                lane = {2{wdata[15:0]}};
                if (!addr[0]) be = addr[1] ? 4'b1100 : 4'b0011;
                else          bad = 1'b1;
            end
            ST_SB: begin
                lane = {4{wdata[7:0]}};
                be   = 4'b0001 << addr[1:0];
            end
            default: bad = 1'b1;
        endcase
    end

    // Out-of-range indices read as zero and never write, so there is no aliasing.
    assign old_word = in_range ? mem[idx] : 32'h0;
    assign wr_be    = (we && in_range) ? be : 4'b0000;

    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) merged_word[8*b +: 8] = lane[8*b +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the RAM is cleared on reset too, so it maps to registers rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            rdata     <= 32'h0;
            addr_lo   <= 2'b00;
            sel_o     <= 2'b00;
            valid     <= 1'b0;
            align_err <= 1'b0;
        end else if (clr) begin
            rdata     <= 32'h0;
            addr_lo   <= 2'b00;
            sel_o     <= 2'b00;
            valid     <= 1'b0;
            align_err <= 1'b0;
        end else if (en) begin
            if (wr_be != 4'b0000) begin
                mem[idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
                $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_word);
`endif
            end
            rdata     <= old_word;
            addr_lo   <= addr[1:0];
            sel_o     <= ld_sel;
            valid     <= 1'b1;
            align_err <= bad & we;
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Directed self-checking bench for dm_stage: expected W-side outputs are queued
// when each step is driven and popped/compared one edge later.
module tb_dm_stage;

    logic        clk = 1'b0;
    logic        reset, en, clr, we;
    logic [31:0] pc, addr, wdata;
    logic [1:0]  st_type, ld_sel;
    logic [31:0] rdata;
    logic [1:0]  addr_lo, sel_o;
    logic        valid, align_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  addr_lo;
        logic [1:0]  sel;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   compared   = 0;
    int   mismatched = 0;

    dm_stage dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .pc        (pc),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .st_type   (st_type),
        .ld_sel    (ld_sel),
        .rdata     (rdata),
        .addr_lo   (addr_lo),
        .sel_o     (sel_o),
        .valid     (valid),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [31:0] r, input logic [1:0] lo, input logic [1:0] s,
                                input logic v, input logic er);
        exp_t e;
        e.rdata   = r;
        e.addr_lo = lo;
        e.sel     = s;
        e.valid   = v;
        e.err     = er;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("%s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic c, input logic e,
                        input logic w, input logic [1:0] st, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] ls, input exp_t ex);
        exp_t got;
        reset   = rst;
        clr     = c;
        en      = e;
        we      = w;
        st_type = st;
        addr    = a;
        wdata   = d;
        ld_sel  = ls;
        pc      = pc + 32'd4;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $display("FAIL %s: observed empty scoreboard, expected one entry", tag);
            $error("%s scoreboard empty", tag);
        end
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check({tag, ".rdata"},     rdata,              got.rdata);
            check({tag, ".addr_lo"},   {30'h0, addr_lo},   {30'h0, got.addr_lo});
            check({tag, ".sel_o"},     {30'h0, sel_o},     {30'h0, got.sel});
            check({tag, ".valid"},     {31'h0, valid},     {31'h0, got.valid});
            check({tag, ".align_err"}, {31'h0, align_err}, {31'h0, got.err});
            last = got;
        end
    endtask

    task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] ls,
                      input logic [31:0] r);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, a, 32'h0, ls, mk(r, a[1:0], ls, 1'b1, 1'b0));
    endtask

    task automatic sto(input string tag, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] old, input logic er);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b1, st, a, d, 2'd0, mk(old, a[1:0], 2'd0, 1'b1, er));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; we = 1'b0;
        pc = 32'h0040_0000; addr = '0; wdata = '0; st_type = '0; ld_sel = '0;
        last = mk(32'h0, 2'd0, 2'd0, 1'b0, 1'b0);

        step("reset0", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0, mk(0, 0, 0, 0, 0));
        step("reset1", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0, mk(0, 0, 0, 0, 0));

        ld("ld_0000", 32'h0000, 2'd2, 32'h0);
        ld("ld_2ffc", 32'h2FFC, 2'd1, 32'h0);

        sto("sw_10",  2'd0, 32'h0010, 32'h12345678, 32'h0,        1'b0);
        sto("sb_11",  2'd2, 32'h0011, 32'h000000AB, 32'h12345678, 1'b0);
        ld("ld_10",   32'h0010, 2'd0, 32'h1234AB78);

        sto("sw_20",  2'd0, 32'h0020, 32'h11223344, 32'h0,        1'b0);
        sto("sh_22",  2'd1, 32'h0022, 32'h0000BEEF, 32'h11223344, 1'b0);
        sto("sh_21",  2'd1, 32'h0021, 32'h0000CAFE, 32'hBEEF3344, 1'b1);
        ld("ld_20",   32'h0020, 2'd2, 32'hBEEF3344);

        sto("sw_26",  2'd0, 32'h0026, 32'hA5A5A5A5, 32'h0, 1'b1);
        sto("rsv_24", 2'd3, 32'h0024, 32'h5A5A5A5A, 32'h0, 1'b1);
        ld("ld_24",   32'h0024, 2'd3, 32'h0);

        step("stall0", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0030, 32'hFFFFFFFF, 2'd1, last);
        step("stall1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0030, 32'hFFFFFFFF, 2'd1, last);
        sto("sw_30",  2'd0, 32'h0030, 32'hFFFFFFFF, 32'h0,        1'b0);
        ld("ld_30a",  32'h0030, 2'd0, 32'hFFFFFFFF);
        sto("sb_33",  2'd2, 32'h0033, 32'h0000009C, 32'hFFFFFFFF, 1'b0);
        sto("sh_30",  2'd1, 32'h0030, 32'h00001357, 32'h9CFFFFFF, 1'b0);
        ld("ld_30b",  32'h0030, 2'd3, 32'h9CFF1357);

        step("clr_st", 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0040, 32'h55555555, 2'd2, mk(0, 0, 0, 0, 0));
        ld("ld_40",   32'h0040, 2'd1, 32'h0);

        sto("sw_3000", 2'd0, 32'h3000, 32'hDEADBEEF, 32'h0, 1'b0);
        ld("ld_3000",  32'h3000, 2'd0, 32'h0);
        ld("ld_0wrap", 32'h0000, 2'd0, 32'h0);
        sto("sw_2ffc", 2'd0, 32'h2FFC, 32'h0BADF00D, 32'h0, 1'b0);
        ld("ld_2ffcb", 32'h2FFC, 2'd2, 32'h0BADF00D);

        step("rst_stall", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0050, 32'h77777777, 2'd1, mk(0, 0, 0, 0, 0));
        ld("ld_2ffc_r", 32'h2FFC, 2'd0, 32'h0);
        ld("ld_10_r",   32'h0010, 2'd0, 32'h0);
        ld("ld_30_r",   32'h0030, 2'd0, 32'h0);
        ld("ld_50_r",   32'h0050, 2'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory-stage data memory for the pipelined MIPS core. It takes the M-stage address, store data and access type, performs byte/halfword/word stores into a word-organised RAM, and reads the addressed word synchronously. It registers the read word together with address bits [1:0] and the load selector, so the W-stage load extender receives aligned inputs one cycle later. It is the block directly upstream of the load extender.

## Interface
- `DEPTH`, 3072: number of 32-bit words; byte addresses 0x0000–0x2FFF.
- `AW`, 12: word-index width; the index is `addr[AW+1:2]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  stage advance; 0 = stall (no write, outputs hold).
- `clr`  in  1  bubble insert on the W side.
- `pc`  in  32  PC of the M-stage instruction; used only for the write log.
- `addr`  in  32  byte address from ALU.
- `wdata`  in  32  store data, right-justified (rt value).
- `we`  in  1  store request.
- `st_type`  in  2  0 = SW, 1 = SH, 2 = SB, 3 = reserved (no write).
- `ld_sel`  in  2  load selector in `DMEXT_*` encoding from head.v; passed through.
- `rdata`  out  32  registered raw word at `addr[AW+1:2]`.
- `addr_lo`  out  2  registered `addr[1:0]`.
- `sel_o`  out  2  registered `ld_sel`.
- `valid`  out  1  W-side entry holds a real instruction.
- `align_err`  out  1  registered misaligned-store flag.

## Operation
- Byte enable `be[3:0]`:
  - SW: `be = 4'b1111`, only when `addr[1:0] == 0`.
  - SH: `be = 4'b0011` when `addr[1] == 0`, `4'b1100` when `addr[1] == 1`; requires `addr[0] == 0`.
  - SB: `be = 4'b0001 << addr[1:0]`.
- Lane shift: SH replicates `wdata[15:0]` to both halves; SB replicates `wdata[7:0]` to all four bytes. Only enabled bytes change.
- Misaligned store (SW with `addr[1:0] != 0`, SH with `addr[0] == 1`) or `st_type == 3`:
  - `be = 0`, so there is no write.
  - `align_err` is set in the next cycle when `we` is high.
- An address with an index ≥ `DEPTH` reads 0 and suppresses the write. No wrap-around.
- Priority per edge: `reset` > `clr` > `!en` > normal.
  - `reset`: clear all RAM words and all outputs to 0.
  - `clr`: outputs go to 0, `valid` goes to 0, no RAM write. A store presented this cycle is dropped.
  - `!en`: RAM unchanged, outputs hold.
  - Normal:
    - Apply the masked write when `we` is high.
    - `rdata` ← RAM word (read-first: pre-write contents).
    - `addr_lo` ← `addr[1:0]`, `sel_o` ← `ld_sel`, `valid` ← 1.
    - `align_err` ← misaligned & `we`.

## Timing
- Reset values: `rdata = 0`, `addr_lo = 0`, `sel_o = 0`, `valid = 0`, `align_err = 0`. All RAM words are 0.
- Store: visible to a read one edge after the write edge.
- Load latency: 1 cycle from M-stage inputs to `rdata`/`addr_lo`/`sel_o`.
- Back-to-back store then load to the same word on consecutive cycles: the load returns the new data.
- Read and write on the same edge: `rdata` returns the old word. Only one instruction per cycle, so this occurs only for a store whose `ld_sel` is ignored downstream.
- Reset asserted mid-stall clears everything on that edge. A pending write is lost.

## Configuration
- `DM_WRITE_LOG_EN`
  - Defined: on every edge with an effective write (`be != 0`, `en`, no `reset`/`clr`), `$display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word)`.
  - Undefined: no display, `pc` unused, identical RTL otherwise.

## Test plan
- Reset then read 0x0000, 0x2FFC -> `rdata = 0`, `valid = 1` after the first non-reset edge.
- SW 0x12345678 @0x0010; SB 0xAB @0x0011; next-cycle load @0x0010 -> `rdata = 0x1234AB78`, `addr_lo = 0`.
- SH 0xBEEF @0x0022 on a word holding 0x11223344 -> word becomes 0xBEEF3344. SH @0x0021 -> no write, `align_err = 1`.
- Stall: `en = 0` with `we = 1` SW 0xFFFFFFFF @0x0030 -> word unchanged, outputs hold previous values. Release `en` -> write occurs.
- `clr = 1` with a store -> `valid = 0`, outputs 0, RAM unchanged. `reset` during a stalled store -> all outputs and RAM are 0.
- Address 0x3000 SW -> no write, `rdata = 0`. With `DM_WRITE_LOG_EN` defined, the log line count equals the number of effective writes.
